// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle RV32I-subset core: opcodes, function
// codes, FSM state encoding, ALU operations and the control bundle.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic       F7B5_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_SLTU  = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {OPB_REG = 2'd0, OPB_IMM = 2'd1, OPB_FOUR = 2'd2} opb_sel_t;
  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_sel_t;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_TARGET = 2'd1} pc_sel_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_LUI, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL
  } iclass_t;

  typedef struct packed {
    logic     ir_we;
    logic     ab_we;
    logic     aluout_we;
    logic     mdr_we;
    logic     rf_we;
    logic     wb_mdr;
    logic     pc_we;
    pc_sel_t  pc_sel;
    logic     opa_pc;
    opb_sel_t opb_sel;
    alu_op_t  alu_op;
    imm_sel_t imm_sel;
  } ctl_t;

  // SLTIU is not part of the supported subset, so funct3=011 is only legal for R-type.
  function automatic logic alu_supported(input logic [2:0] f3, input logic is_r);
    case (f3)
      F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND: alu_supported = 1'b1;
      F3_SLTU:                               alu_supported = is_r;
      default:                               alu_supported = 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      F3_ADD:  alu_decode = (is_r && f7b5 == F7B5_SUB) ? ALU_SUB : ALU_ADD;
      F3_SLT:  alu_decode = ALU_SLT;
      F3_SLTU: alu_decode = ALU_SLTU;
      F3_XOR:  alu_decode = ALU_XOR;
      F3_OR:   alu_decode = ALU_OR;
      F3_AND:  alu_decode = ALU_AND;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rv_ctl.sv
// Control unit: five-state instruction FSM plus instruction-class decode that
// produces the per-cycle datapath control bundle and the memory write strobe.
module rv_ctl
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       a_eq_b,
  output ctl_t       ctl,
  output logic       memrw
);

  state_t  current;
  state_t  current_d;
  iclass_t iclass;
  logic    taken;

  always_comb begin
    iclass = CL_NOP;
    case (opcode)
      OP_R:      if (alu_supported(funct3, 1'b1)) iclass = CL_ALU;
      OP_I:      if (alu_supported(funct3, 1'b0)) iclass = CL_ALU;
      OP_LUI:    iclass = CL_LUI;
      OP_LOAD:   if (funct3 == F3_LW) iclass = CL_LOAD;
      OP_STORE:  if (funct3 == F3_SW) iclass = CL_STORE;
      OP_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) iclass = CL_BRANCH;
      OP_JAL:    iclass = CL_JAL;
      default:   iclass = CL_NOP;
    endcase
  end

  assign taken = (funct3 == F3_BNE) ? !a_eq_b : a_eq_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) current <= ST_FETCH;
    else     current <= current_d;
  end

  always_comb begin
    current_d = current;
    ctl       = '0;
    memrw     = 1'b0;

    // Operand routing depends only on the instruction; write enables gate its use.
    case (iclass)
      CL_STORE:  ctl.imm_sel = IMM_S;
      CL_BRANCH: ctl.imm_sel = IMM_B;
      CL_JAL:    ctl.imm_sel = IMM_J;
      CL_LUI:    ctl.imm_sel = IMM_U;
      default:   ctl.imm_sel = IMM_I;
    endcase
    case (iclass)
      CL_ALU:  ctl.alu_op = alu_decode(funct3, funct7b5, opcode == OP_R);
      CL_LUI:  ctl.alu_op = ALU_PASSB;
      default: ctl.alu_op = ALU_ADD;
    endcase
    if (iclass == CL_JAL)     ctl.opb_sel = OPB_FOUR;
    else if (opcode == OP_R)  ctl.opb_sel = OPB_REG;
    else                      ctl.opb_sel = OPB_IMM;
    ctl.opa_pc = (iclass == CL_JAL);

    case (current)
      ST_FETCH: begin
        ctl.ir_we = 1'b1;
        current_d = ST_DECODE;
      end
      ST_DECODE: begin
        ctl.ab_we = 1'b1;
        current_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (iclass)
          CL_ALU, CL_LUI, CL_JAL: begin
            ctl.aluout_we = 1'b1;
            current_d     = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            ctl.aluout_we = 1'b1;
            current_d     = ST_MEM;
          end
          CL_BRANCH: begin
            ctl.pc_we  = 1'b1;
            ctl.pc_sel = taken ? PC_TARGET : PC_PLUS4;
            current_d  = ST_FETCH;
          end
          default: begin
            ctl.pc_we = 1'b1;
            current_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        if (iclass == CL_LOAD) begin
          ctl.mdr_we = 1'b1;
          current_d  = ST_WB;
        end else begin
          memrw     = (iclass == CL_STORE);
          ctl.pc_we = 1'b1;
          current_d = ST_FETCH;
        end
      end
      ST_WB: begin
        ctl.rf_we  = 1'b1;
        ctl.wb_mdr = (iclass == CL_LOAD);
        ctl.pc_we  = 1'b1;
        ctl.pc_sel = (iclass == CL_JAL) ? PC_TARGET : PC_PLUS4;
        current_d  = ST_FETCH;
      end
      default: current_d = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/rv_dp.sv
// Datapath: PC, instruction register, operand/result registers, register
// file, immediate generator and ALU, all steered by the control bundle.
module rv_dp
  import rv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  ctl_t         ctl,
  output logic [W-1:0] imem_addr,
  input  logic [31:0]  imem_datain,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_dataout,
  input  logic [W-1:0] dmem_datain,
  output logic [6:0]   opcode,
  output logic [2:0]   funct3,
  output logic         funct7b5,
  output logic         a_eq_b
);

  logic [W-1:0] pcc, pcc_d;
  logic [31:0]  ir, ir_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
  logic [W-1:0] rf_q [32];
  logic [4:0]   rs1, rs2, rd;
  logic [W-1:0] imm, opa, opb, alu_res, rf_wdata;
  logic         rf_wen;

  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rd       = ir[11:7];
  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign funct7b5 = ir[30];

  always_comb begin
    case (ctl.imm_sel)
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'b0};
      default: imm = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  always_comb begin
    opa = ctl.opa_pc ? pcc : a_q;
    case (ctl.opb_sel)
      OPB_IMM:  opb = imm;
      OPB_FOUR: opb = W'(4);
      default:  opb = b_q;
    endcase
    case (ctl.alu_op)
      ALU_SUB:   alu_res = opa - opb;
      ALU_AND:   alu_res = opa & opb;
      ALU_OR:    alu_res = opa | opb;
      ALU_XOR:   alu_res = opa ^ opb;
      ALU_SLT:   alu_res = {{(W-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU:  alu_res = {{(W-1){1'b0}}, opa < opb};
      ALU_PASSB: alu_res = opb;
      default:   alu_res = opa + opb;
    endcase
  end

  always_comb begin
    ir_d     = ctl.ir_we     ? imem_datain : ir;
    a_d      = ctl.ab_we     ? rf_q[rs1]   : a_q;
    b_d      = ctl.ab_we     ? rf_q[rs2]   : b_q;
    aluout_d = ctl.aluout_we ? alu_res     : aluout_q;
    mdr_d    = ctl.mdr_we    ? dmem_datain : mdr_q;
    pcc_d    = pcc;
    if (ctl.pc_we) pcc_d = (ctl.pc_sel == PC_TARGET) ? pcc + imm : pcc + W'(4);
    // x0 is never written, so its reset value keeps it reading zero.
    rf_wen   = ctl.rf_we && (rd != 5'd0);
    rf_wdata = ctl.wb_mdr ? mdr_q : aluout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcc      <= '0;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pcc      <= pcc_d;
      ir       <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      if (rf_wen) rf_q[rd] <= rf_wdata;
    end
  end

  assign imem_addr    = pcc;
  assign dmem_addr    = aluout_q;
  assign dmem_dataout = b_q;
  assign a_eq_b       = (a_q == b_q);

endmodule

// File: rtl/rv_top.sv
// Multicycle RV32I-subset core: control FSM (ctl) driving a non-pipelined
// datapath (dp) between a combinational instruction ROM and data RAM.
module rv_top
  import rv_pkg::*;
#(
  parameter int DPWIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [DPWIDTH-1:0] imem_addr,
  input  logic [31:0]        imem_datain,
  output logic [DPWIDTH-1:0] dmem_addr,
  output logic [DPWIDTH-1:0] dmem_dataout,
  output logic               memrw,
  input  logic [DPWIDTH-1:0] dmem_datain
);

  ctl_t       ctl_bus;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       a_eq_b;

  rv_ctl ctl (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .a_eq_b   (a_eq_b),
    .ctl      (ctl_bus),
    .memrw    (memrw)
  );

  rv_dp #(.W(DPWIDTH)) dp (
    .clk          (clk),
    .rst          (rst),
    .ctl          (ctl_bus),
    .imem_addr    (imem_addr),
    .imem_datain  (imem_datain),
    .dmem_addr    (dmem_addr),
    .dmem_dataout (dmem_dataout),
    .dmem_datain  (dmem_datain),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .a_eq_b       (a_eq_b)
  );

endmodule

// File: tb/tb_rv_top.sv
// Bench for rv_top: a directed program with hand-computed stores and PC/cycle
// sequence; a monitor pops expectations whenever the core stores or decodes.
module tb_rv_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_datain;
  logic [31:0] dmem_addr, dmem_dataout, dmem_datain;
  logic        memrw;

  logic [31:0] prog [64];
  int          plen [64];
  int          n_prog;
  logic [31:0] dmem [64];
  logic        dmem_init;

  logic [63:0] exp_q [$];
  logic [31:0] pc_q [$];
  int          len_q [$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic done     = 1'b0;
  int   cyc      = 0;
  int   last_dec_cyc;
  int   prev_len;
  logic dec_seen = 1'b0;
  int   seq [7] = '{1, 2, 3, 4, 0, 1, 2};

  rv_top #(.DPWIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_datain  (imem_datain),
    .dmem_addr    (dmem_addr),
    .dmem_dataout (dmem_dataout),
    .memrw        (memrw),
    .dmem_datain  (dmem_datain)
  );

  // Clock and memories
  always #5 clk = ~clk;

  assign imem_datain = prog[imem_addr[7:2]];
  assign dmem_datain = dmem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (dmem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
      dmem[1] <= 32'h12345678;
    end else if (memrw && dmem_addr[31:8] == 24'h0) begin
      dmem[dmem_addr[7:2]] <= dmem_dataout;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    logic [11:0] im;
    im = imm[11:0];
    return {im, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [20:0] im;
    im = imm[20:0];
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic emit(input logic [31:0] word, input int len);
    prog[n_prog] = word;
    plen[n_prog] = len;
    n_prog++;
  endtask

  task automatic exp_store(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Monitor: compares stores and the PC/cycle count seen at each DECODE
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      cyc = cyc + 1;
      if (memrw) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_store: got addr %h data %h expected no store", dmem_addr, dmem_dataout);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("store", {dmem_addr, dmem_dataout}, e);
          if (dmem_addr == 32'h0000FFFF && dmem_dataout == 32'h0000DEAD) done = 1'b1;
        end
      end
      if (dut.ctl.current == 3'd1) begin
        if (dec_seen) check("insn_cycles", 64'(cyc - last_dec_cyc), 64'(prev_len));
        if (pc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pc_unexpected: got pc %h expected no further decode", imem_addr);
        end else begin
          check("decode_pc", {32'h0, imem_addr}, {32'h0, pc_q.pop_front()});
          prev_len = len_q.pop_front();
        end
        last_dec_cyc = cyc;
        dec_seen     = 1'b1;
      end
    end
  end

  // Stimulus
  initial begin
    int path [$];
    rst       = 1'b1;
    dmem_init = 1'b1;
    n_prog    = 0;
    for (int i = 0; i < 64; i++) begin
      prog[i] = enc_j(0, 5'd0);
      plen[i] = 4;
    end

    emit(enc_i(4, 0, 3'b010, 7, 7'b0000011), 5);       // 0x00 LW   x7,4(x0)
    emit(enc_s(16, 7, 0), 4);                          // 0x04 SW   x7,16(x0)
    emit(enc_i(5, 0, 3'b000, 1, 7'b0010011), 4);       // 0x08 ADDI x1,x0,5
    emit(enc_i(-3, 0, 3'b000, 2, 7'b0010011), 4);      // 0x0C ADDI x2,x0,-3
    emit(enc_r(7'h00, 2, 1, 3'b000, 3), 4);            // 0x10 ADD  x3,x1,x2
    emit(enc_r(7'h20, 2, 1, 3'b000, 4), 4);            // 0x14 SUB  x4,x1,x2
    emit(enc_r(7'h00, 1, 2, 3'b010, 5), 4);            // 0x18 SLT  x5,x2,x1
    emit(enc_r(7'h00, 1, 2, 3'b011, 6), 4);            // 0x1C SLTU x6,x2,x1
    emit(enc_s(0, 3, 0), 4);                           // 0x20 SW   x3,0(x0)
    emit(enc_s(4, 4, 0), 4);                           // 0x24 SW   x4,4(x0)
    emit(enc_s(8, 5, 0), 4);                           // 0x28 SW   x5,8(x0)
    emit(enc_s(12, 6, 0), 4);                          // 0x2C SW   x6,12(x0)
    emit(enc_r(7'h00, 2, 1, 3'b100, 8), 4);            // 0x30 XOR  x8,x1,x2
    emit(enc_r(7'h00, 2, 1, 3'b110, 9), 4);            // 0x34 OR   x9,x1,x2
    emit(enc_r(7'h00, 1, 9, 3'b111, 10), 4);           // 0x38 AND  x10,x9,x1
    emit(enc_i(12'h0F0, 9, 3'b111, 11, 7'b0010011), 4);// 0x3C ANDI x11,x9,0xF0
    emit(enc_i(-16, 1, 3'b110, 12, 7'b0010011), 4);    // 0x40 ORI  x12,x1,-16
    emit(enc_i(-1, 1, 3'b100, 13, 7'b0010011), 4);     // 0x44 XORI x13,x1,-1
    emit(enc_i(-2, 2, 3'b010, 14, 7'b0010011), 4);     // 0x48 SLTI x14,x2,-2
    emit(enc_s(24, 8, 0), 4);                          // 0x4C
    emit(enc_s(28, 10, 0), 4);                         // 0x50
    emit(enc_s(32, 11, 0), 4);                         // 0x54
    emit(enc_s(36, 12, 0), 4);                         // 0x58
    emit(enc_s(40, 13, 0), 4);                         // 0x5C
    emit(enc_s(44, 14, 0), 4);                         // 0x60
    emit(enc_s(48, 9, 0), 4);                          // 0x64
    emit(enc_b(8, 1, 1, 3'b000), 3);                   // 0x68 BEQ x1,x1,+8 taken
    emit(enc_i(1, 0, 3'b000, 15, 7'b0010011), 4);      // 0x6C skipped
    emit(enc_b(8, 1, 1, 3'b001), 3);                   // 0x70 BNE x1,x1 not taken
    emit(enc_i(2, 15, 3'b000, 15, 7'b0010011), 4);     // 0x74 ADDI x15,x15,2
    emit(enc_b(8, 2, 1, 3'b001), 3);                   // 0x78 BNE x1,x2,+8 taken
    emit(enc_i(4, 15, 3'b000, 15, 7'b0010011), 4);     // 0x7C skipped
    emit(enc_b(8, 2, 1, 3'b000), 3);                   // 0x80 BEQ x1,x2 not taken
    emit(enc_j(8, 16), 4);                             // 0x84 JAL x16,+8
    emit(enc_i(8, 15, 3'b000, 15, 7'b0010011), 4);     // 0x88 skipped
    emit(enc_s(52, 15, 0), 4);                         // 0x8C SW x15,52(x0)
    emit(enc_s(56, 16, 0), 4);                         // 0x90 SW x16,56(x0)
    emit(enc_i(7, 0, 3'b000, 0, 7'b0010011), 4);       // 0x94 ADDI x0,x0,7
    emit(enc_s(20, 0, 0), 4);                          // 0x98 SW x0,20(x0)
    emit(32'h0000000B, 3);                             // 0x9C unsupported -> NOP
    emit(enc_u(20'h00010, 1), 4);                      // 0xA0 LUI x1,0x10
    emit(enc_i(-1, 1, 3'b000, 1, 7'b0010011), 4);      // 0xA4 ADDI x1,x1,-1
    emit(enc_u(20'h0000E, 2), 4);                      // 0xA8 LUI x2,0xE
    emit(enc_i(-339, 2, 3'b000, 2, 7'b0010011), 4);    // 0xAC ADDI x2,x2,-339
    emit(enc_s(0, 2, 1), 4);                           // 0xB0 SW x2,0(x1)
    emit(enc_j(0, 0), 4);                              // 0xB4 JAL x0,0

    exp_store(32'd16, 32'h12345678);
    exp_store(32'd0,  32'd2);
    exp_store(32'd4,  32'd8);
    exp_store(32'd8,  32'd1);
    exp_store(32'd12, 32'd0);
    exp_store(32'd24, 32'hFFFFFFF8);
    exp_store(32'd28, 32'd5);
    exp_store(32'd32, 32'h000000F0);
    exp_store(32'd36, 32'hFFFFFFF5);
    exp_store(32'd40, 32'hFFFFFFFA);
    exp_store(32'd44, 32'd1);
    exp_store(32'd48, 32'hFFFFFFFD);
    exp_store(32'd52, 32'd2);
    exp_store(32'd56, 32'h00000088);
    exp_store(32'd20, 32'd0);
    exp_store(32'h0000FFFF, 32'h0000DEAD);

    for (int i = 0; i <= 26; i++) path.push_back(i);
    path.push_back(28); path.push_back(29); path.push_back(30);
    path.push_back(32); path.push_back(33);
    for (int i = 35; i <= 45; i++) path.push_back(i);
    foreach (path[k]) begin
      pc_q.push_back(32'(path[k] * 4));
      len_q.push_back(plen[path[k]]);
    end

    // Reset values, then release and abort an SW mid-instruction
    repeat (5) begin
      @(negedge clk);
      check("rst_state", 64'(dut.ctl.current), 64'd0);
      check("rst_pc", 64'(imem_addr), 64'd0);
      check("rst_memrw", 64'(memrw), 64'd0);
    end
    dmem_init = 1'b0;
    check("rst_ir", 64'(dut.dp.ir), 64'd0);
    rst = 1'b0;
    #1 check("release_state", 64'(dut.ctl.current), 64'd0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("seq_state", 64'(dut.ctl.current), 64'(seq[k]));
      check("seq_memrw", 64'(memrw), 64'd0);
      if (k == 4) check("lw_next_pc", 64'(imem_addr), 64'd4);
    end
    rst = 1'b1;
    #1;
    check("abort_state", 64'(dut.ctl.current), 64'd0);
    check("abort_pc", 64'(imem_addr), 64'd0);
    check("abort_memrw", 64'(memrw), 64'd0);
    check("abort_ir", 64'(dut.dp.ir), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_memrw", 64'(memrw), 64'd0);
    end
    check("abort_no_store", 64'(dmem[4]), 64'd0);

    // Full program run
    mon_en = 1'b1;
    rst    = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) @(posedge clk);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no completion store expected 0x0000DEAD at 0x0000FFFF");
    end
    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    check("store_q_empty", 64'(exp_q.size()), 64'd0);
    check("pc_q_empty", 64'(pc_q.size()), 64'd0);
    check("dmem_word16", 64'(dmem[4]), 64'h12345678);
    check("dmem_word0", 64'(dmem[0]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
